// File: rtl/control_pkg.sv
// Shared constants for the MIPS main control decoder: opcodes, ALUOp classes
// and the bit positions of the control strobes on the signals bus.
package control_pkg;

  localparam int SIG_W = 7;

  localparam int SIG_REGDST   = 0;
  localparam int SIG_BRANCH   = 1;
  localparam int SIG_MEMREAD  = 2;
  localparam int SIG_MEMTOREG = 3;
  localparam int SIG_MEMWRITE = 4;
  localparam int SIG_ALUSRC   = 5;
  localparam int SIG_REGWRITE = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SLTU  = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b111;

endpackage

// File: rtl/control_unit_if.sv
// Opcode in, registered control strobes and ALU class out.
interface control_unit_if #(parameter int NUM_SIGNALS = 7);
  logic [5:0]             ins;
  logic [NUM_SIGNALS-1:0] signals;
  logic [2:0]             ALUOp;

  modport master (output ins, input signals, input ALUOp);
  modport slave  (input ins, output signals, output ALUOp);
endinterface

// File: rtl/control_decode.sv
// Purely combinational opcode decode; unknown or unlisted opcodes fall to the
// all-zero row so nothing is written to registers or memory.
module control_decode
  import control_pkg::*;
(
  input  logic [5:0]       ins_i,
  output logic [SIG_W-1:0] next_signals_o,
  output logic [2:0]       next_aluop_o
);

  always_comb begin
    next_signals_o = '0;
    next_aluop_o   = ALU_ADD;
    case (ins_i)
      OP_RTYPE: begin
        next_signals_o[SIG_REGWRITE] = 1'b1;
        next_signals_o[SIG_REGDST]   = 1'b1;
        next_aluop_o                 = ALU_FUNCT;
      end
      OP_LW, OP_LBU, OP_LHU: begin
        next_signals_o[SIG_REGWRITE] = 1'b1;
        next_signals_o[SIG_ALUSRC]   = 1'b1;
        next_signals_o[SIG_MEMTOREG] = 1'b1;
        next_signals_o[SIG_MEMREAD]  = 1'b1;
      end
      OP_SW, OP_SB, OP_SH: begin
        next_signals_o[SIG_ALUSRC]   = 1'b1;
        next_signals_o[SIG_MEMWRITE] = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        next_signals_o[SIG_BRANCH] = 1'b1;
        next_aluop_o               = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
        next_signals_o[SIG_REGWRITE] = 1'b1;
        next_signals_o[SIG_ALUSRC]   = 1'b1;
        case (ins_i)
          OP_ANDI:  next_aluop_o = ALU_AND;
          OP_ORI:   next_aluop_o = ALU_OR;
          OP_SLTI:  next_aluop_o = ALU_SLT;
          OP_SLTIU: next_aluop_o = ALU_SLTU;
          OP_LUI:   next_aluop_o = ALU_LUI;
          default:  next_aluop_o = ALU_ADD;
        endcase
      end
      // Jumps carry no strobes here; target steering lives outside this block.
      OP_J, OP_JAL: begin
        next_signals_o = '0;
        next_aluop_o   = ALU_ADD;
      end
      default: begin
        next_signals_o = '0;
        next_aluop_o   = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// MIPS main control: decode the opcode and register the strobes so they line
// up with the following pipeline stage (one cycle of latency).
module control_unit
  import control_pkg::*;
#(
  parameter int NUM_SIGNALS = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  control_unit_if.slave bus
);

  logic [SIG_W-1:0] signals_d, signals_q;
  logic [2:0]       aluop_d, aluop_q;

  control_decode u_decode (
    .ins_i          (bus.ins),
    .next_signals_o (signals_d),
    .next_aluop_o   (aluop_d)
  );

  // Stage boundary: decoded strobes registered toward the next pipeline stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signals_q <= '0;
      aluop_q   <= ALU_ADD;
    end else begin
      signals_q <= signals_d;
      aluop_q   <= aluop_d;
    end
  end

  assign bus.signals = signals_q;
  assign bus.ALUOp   = aluop_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset behaviour, latency, decode table,
// mid-stream reset, invariants and a full opcode sweep against a golden table.
module tb_control_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  control_unit_if #(.NUM_SIGNALS(7)) bus ();

  control_unit #(.NUM_SIGNALS(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] golden(input logic [5:0] op);
    logic [9:0] r;
    case (op)
      6'd0:               r = {7'b1000001, 3'b010};
      6'd35, 6'd36, 6'd37: r = {7'b1101100, 3'b000};
      6'd43, 6'd40, 6'd41: r = {7'b0110000, 3'b000};
      6'd4, 6'd5:         r = {7'b0000010, 3'b001};
      6'd8, 6'd9:         r = {7'b1100000, 3'b000};
      6'd12:              r = {7'b1100000, 3'b011};
      6'd13:              r = {7'b1100000, 3'b100};
      6'd10:              r = {7'b1100000, 3'b101};
      6'd11:              r = {7'b1100000, 3'b110};
      6'd15:              r = {7'b1100000, 3'b111};
      default:            r = 10'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [6:0] es, input logic [2:0] ea);
    checks++;
    assert (bus.signals === es && bus.ALUOp === ea) else begin
      fails++;
      $error("FAIL %s: observed %b/%b expected %b/%b", tag, bus.signals, bus.ALUOp, es, ea);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] op,
                      input logic [6:0] es, input logic [2:0] ea);
    @(negedge clk);
    bus.ins = op;
    @(posedge clk);
    #1;
    chk(tag, es, ea);
  endtask

  // Invariants sampled on every falling edge while out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (!(bus.signals[4] && bus.signals[2]) && (!bus.signals[3] || bus.signals[2])) else begin
        fails++;
        $error("FAIL invariant: observed %b expected no rd&wr, memtoreg->memread", bus.signals);
      end
    end
  end

  initial begin
    logic [5:0] op;
    logic [9:0] g;
    int         start;
    checks  = 0;
    fails   = 0;
    rst_n   = 1'b1;
    bus.ins = 6'b100011;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", 7'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", 7'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_no_edge", 7'b0, 3'b000);
    @(posedge clk);
    #1 chk("first_edge_lw", 7'b1101100, 3'b000);

    @(negedge clk);
    bus.ins = 6'b000000;
    #1 chk("latency_before", 7'b1101100, 3'b000);
    @(posedge clk);
    #1 chk("latency_after_rtype", 7'b1000001, 3'b010);

    step("lw",    6'b100011, 7'b1101100, 3'b000);
    step("sw",    6'b101011, 7'b0110000, 3'b000);
    step("sh",    6'b101001, 7'b0110000, 3'b000);
    step("beq",   6'b000100, 7'b0000010, 3'b001);
    step("andi",  6'b001100, 7'b1100000, 3'b011);
    step("ori",   6'b001101, 7'b1100000, 3'b100);
    step("slti",  6'b001010, 7'b1100000, 3'b101);
    step("sltiu", 6'b001011, 7'b1100000, 3'b110);
    step("addi",  6'b001000, 7'b1100000, 3'b000);
    step("lui",   6'b001111, 7'b1100000, 3'b111);
    step("j",     6'b000010, 7'b0000000, 3'b000);
    step("jal",   6'b000011, 7'b0000000, 3'b000);
    step("ill_27", 6'b100111, 7'b0000000, 3'b000);
    step("ill_3f", 6'b111111, 7'b0000000, 3'b000);
    step("lw_again", 6'b100011, 7'b1101100, 3'b000);

    #2 rst_n = 1'b0;
    #1 chk("midstream_reset", 7'b0, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midstream_release", 7'b0, 3'b000);

    start = int'($urandom_range(0, 63));
    for (int i = 0; i < 64; i++) begin
      op = 6'((start + i * 37) % 64);
      g  = golden(op);
      step($sformatf("sweep_%02h", op), op, g[9:3], g[2:0]);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
